scroll_tick_ctrl: RTL and testbench
===================================

Name: scroll_tick_ctrl

Overview:
Downstream consumer of the prescaler's slow output, clocked by the same fast clock. It turns each rising edge of the prescaler output into a one-cycle tick, which drives a character scroll offset for a text marquee in the font display path. It also drives a cursor blink flag.
- Modes: free-run, single-step and direction control.
- Wrap-around is based on a run-time message length.

Parameters:
LEN_W, 6, width of message length and offset (max 63 characters)
BLINK_DIV, 4, slow-clock edges per blink half-period (must be >= 1)
BLINK_W, 3, width of blink edge counter (2^BLINK_W >= BLINK_DIV)

Ports:
clk_in  in  1  fast system clock; all logic on rising edge
rstn  in  1  asynchronous active-low reset
slow_clk  in  1  prescaler output (MSB of its counter), synchronous to clk_in
run  in  1  1 = advance on every slow_clk rising edge; 0 = paused
step  in  1  level from button logic; each rising edge advances once while paused
dir  in  1  0 = offset increments, 1 = offset decrements
msg_len  in  LEN_W  message length in characters; 0 is treated as 1
offset  out  LEN_W  current first-character index, 0..len_eff-1
tick  out  1  one-cycle pulse per detected slow_clk rising edge
wrap  out  1  one-cycle pulse when offset wraps
blink  out  1  cursor visible flag, toggles every BLINK_DIV edges

Behaviour:
- Reset (async assert, sync-effect release):
  - offset=0, tick=0, wrap=0, blink=1, blink counter=0.
  - The edge-history registers for slow_clk and step reset to 1. A signal already high at reset release therefore produces no edge until it has been seen low.
- Edge detection:
  - se = slow_clk & ~slow_q.
  - pe = step & ~step_q.
  - slow_q and step_q are registered copies of the inputs, updated every cycle.
- Derived terms:
  - len_eff = (msg_len==0) ? 1 : msg_len.
  - adv = (run & se) | (~run & pe). step is ignored while run=1.
- Latency: every output is registered. An edge sampled in cycle n is reflected in the outputs in cycle n+1.
- tick: equals se delayed one cycle, independent of run.
- Offset update, priority order:
  1. Out of range: if offset >= len_eff (msg_len shrank), next offset=0 and wrap=0. A simultaneous adv is dropped.
  2. adv with dir=0: if offset == len_eff-1, next offset=0 and wrap=1; else offset+1.
  3. adv with dir=1: if offset == 0, next offset=len_eff-1 and wrap=1; else offset-1.
  4. Otherwise offset holds and wrap=0.
- len_eff=1: every adv produces offset=0 with wrap=1.
- Blink:
  - On each se, regardless of run, the counter increments.
  - When the counter == BLINK_DIV-1 it clears to 0 and blink toggles.
- dir and msg_len are sampled in the cycle adv is evaluated. Changing them mid-run takes effect on the next edge.
- Reset mid-operation: all state returns to the reset values immediately. No tick or wrap may be emitted on the first cycle after release unless a genuine low-to-high edge is seen.
- Arithmetic is modulo 2^LEN_W internally; the wrap rules above guarantee no overflow.

Test Plan:
1. Reset release with slow_clk=1, run=1, msg_len=4: hold for 10 cycles -> tick=0, offset=0, blink=1. Drive slow_clk low then high -> one tick, offset=1 one cycle after the rising edge.
2. run=1, dir=0, msg_len=4, 5 slow edges -> offset 1,2,3,0,1. wrap pulses exactly once, at the 3->0 transition. tick pulses 5 times, each 1 cycle wide.
3. run=1, dir=1, msg_len=3, from offset 0, 4 edges -> offset 2,1,0,2. wrap on the 0->2 transitions (edges 1 and 4).
4. run=0, slow edges toggling, three step pulses (step also held high for 20 cycles once) -> offset advances exactly 3. Slow edges still produce tick. BLINK_DIV=4: blink toggles after edges 4 and 8.
5. offset=5, msg_len changed to 3 with a coincident adv -> next cycle offset=0, wrap=0. msg_len=0 -> each adv gives offset=0, wrap=1.
6. Assert rstn low mid-run at offset=2, blink=0 -> offset=0, blink=1, tick=wrap=0 asynchronously. Release with slow_clk high -> no tick until the next genuine rising edge.

Source files
------------

// File: rtl/scroll_tick_ctrl.sv
// scroll_tick_ctrl: converts rising edges of the prescaler's slow output into
// one-cycle ticks. The ticks step a wrapping character offset for a text
// marquee and drive a cursor blink flag. Advancing can be free-running
// (every slow edge) or single-stepped from a button level while paused.
// All outputs are registered, so an edge sampled in cycle n is visible in
// cycle n+1.
module scroll_tick_ctrl #(
    parameter int LEN_W     = 6,
    parameter int BLINK_DIV = 4,
    parameter int BLINK_W   = 3
) (
    input  logic             clk_in,
    input  logic             rstn,
    input  logic             slow_clk,
    input  logic             run,
    input  logic             step,
    input  logic             dir,
    input  logic [LEN_W-1:0] msg_len,
    output logic [LEN_W-1:0] offset,
    output logic             tick,
    output logic             wrap,
    output logic             blink
);

    // Edge history; resetting these high means a level that is already
    // high at reset release must be seen low before it can count as an edge.
    logic               slow_q;
    logic               step_q;
    logic [BLINK_W-1:0] blink_cnt;

    logic               se;
    logic               pe;
    logic               adv;
    logic [LEN_W-1:0]   len_eff;
    logic [LEN_W-1:0]   last_idx;

    // Forward step with wrap at the last valid character.
    function automatic logic [LEN_W-1:0] step_up(input logic [LEN_W-1:0] cur,
                                                  input logic [LEN_W-1:0] last);
        return (cur == last) ? '0 : cur + LEN_W'(1);
    endfunction

    // Backward step with wrap from character 0 to the last valid character.
    function automatic logic [LEN_W-1:0] step_down(input logic [LEN_W-1:0] cur,
                                                    input logic [LEN_W-1:0] last);
        return (cur == '0) ? last : cur - LEN_W'(1);
    endfunction

    // Edge detection and the advance qualifier; step only matters while paused.
    always_comb begin
        se       = slow_clk & ~slow_q;
        pe       = step & ~step_q;
        adv      = (run & se) | (~run & pe);
        len_eff  = (msg_len == '0) ? LEN_W'(1) : msg_len;
        last_idx = len_eff - LEN_W'(1);
    end

    // Input history registers, sampled every cycle.
    always_ff @(posedge clk_in or negedge rstn) begin
        if (!rstn) begin
            slow_q <= 1'b1;
            step_q <= 1'b1;
        end else begin
            slow_q <= slow_clk;
            step_q <= step;
        end
    end

    // Tick is the slow-clock edge delayed one cycle, independent of run.
    always_ff @(posedge clk_in or negedge rstn) begin
        if (!rstn) begin
            tick <= 1'b0;
        end else begin
            tick <= se;
        end
    end

    // Offset and wrap: a shrunken message length forces the offset back to 0
    // and swallows any coincident advance; otherwise advance in the chosen
    // direction, flagging wrap when crossing the message boundary.
    always_ff @(posedge clk_in or negedge rstn) begin
        if (!rstn) begin
            offset <= '0;
            wrap   <= 1'b0;
        end else if (offset >= len_eff) begin
            offset <= '0;
            wrap   <= 1'b0;
        end else if (adv && !dir) begin
            offset <= step_up(offset, last_idx);
            wrap   <= (offset == last_idx);
        end else if (adv && dir) begin
            offset <= step_down(offset, last_idx);
            wrap   <= (offset == '0);
        end else begin
            wrap   <= 1'b0;
        end
    end

    // Cursor blink: count slow edges and toggle every BLINK_DIV of them.
    always_ff @(posedge clk_in or negedge rstn) begin
        if (!rstn) begin
            blink_cnt <= '0;
            blink     <= 1'b1;
        end else if (se) begin
            if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
                blink_cnt <= '0;
                blink     <= ~blink;
            end else begin
                blink_cnt <= blink_cnt + BLINK_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_scroll_tick_ctrl.sv
// Testbench for scroll_tick_ctrl. Stimulus is applied on the falling clock
// edge; a reference model predicts the registered outputs after the next
// rising edge and queues them. A monitor pops and compares shortly after
// every rising edge.
module tb_scroll_tick_ctrl;

    localparam int LEN_W     = 6;
    localparam int BLINK_DIV = 4;

    logic             clk_in = 1'b0;
    logic             rstn;
    logic             slow_clk;
    logic             run;
    logic             step;
    logic             dir;
    logic [LEN_W-1:0] msg_len;
    logic [LEN_W-1:0] offset;
    logic             tick;
    logic             wrap;
    logic             blink;

    always #5 clk_in = ~clk_in;

    scroll_tick_ctrl #(
        .LEN_W    (LEN_W),
        .BLINK_DIV(BLINK_DIV),
        .BLINK_W  (3)
    ) dut (
        .clk_in  (clk_in),
        .rstn    (rstn),
        .slow_clk(slow_clk),
        .run     (run),
        .step    (step),
        .dir     (dir),
        .msg_len (msg_len),
        .offset  (offset),
        .tick    (tick),
        .wrap    (wrap),
        .blink   (blink)
    );

    typedef struct {
        int off;
        bit tk;
        bit wr;
        bit bl;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Staged control inputs, copied onto the DUT at the falling edge.
    logic             n_run;
    logic             n_dir;
    logic [LEN_W-1:0] n_len;

    // Reference model state: previous input levels, offset, edge count.
    bit m_slow_q;
    bit m_step_q;
    int m_off;
    int m_edges;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: actual=%0d expected=%0d", nm, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_slow_q = 1'b1;
        m_step_q = 1'b1;
        m_off    = 0;
        m_edges  = 0;
        q.delete();
    endtask

    // Predict the outputs after the coming rising edge from current inputs.
    task automatic apply_and_push();
        exp_t e;
        int   len;
        bit   se;
        bit   pe;
        bit   adv;
        se  = (slow_clk === 1'b1) && !m_slow_q;
        pe  = (step === 1'b1) && !m_step_q;
        len = (msg_len == 0) ? 1 : int'(msg_len);
        adv = run ? se : pe;
        e.wr = 1'b0;
        if (m_off >= len) begin
            m_off = 0;
        end else if (adv) begin
            if (!dir) begin
                e.wr  = (m_off == len - 1);
                m_off = (m_off + 1) % len;
            end else begin
                e.wr  = (m_off == 0);
                m_off = (m_off + len - 1) % len;
            end
        end
        if (se) m_edges++;
        e.off = m_off;
        e.tk  = se;
        e.bl  = ((m_edges / BLINK_DIV) % 2) == 0;
        m_slow_q = slow_clk;
        m_step_q = step;
        q.push_back(e);
    endtask

    task automatic cyc(input logic s, input logic st);
        @(negedge clk_in);
        slow_clk = s;
        step     = st;
        run      = n_run;
        dir      = n_dir;
        msg_len  = n_len;
        apply_and_push();
    endtask

    task automatic edges(input int n);
        repeat (n) begin
            cyc(1'b0, 1'b0);
            cyc(1'b1, 1'b0);
            cyc(1'b1, 1'b0);
        end
    endtask

    // Assert reset between clock edges, check the asynchronous clear,
    // then release on a falling edge with slow_clk at level s.
    task automatic do_reset(input int hold, input logic s);
        @(negedge clk_in);
        slow_clk = s;
        step     = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        chk("rst_offset", int'(offset), 0);
        chk("rst_tick", int'(tick), 0);
        chk("rst_wrap", int'(wrap), 0);
        chk("rst_blink", int'(blink), 1);
        model_reset();
        repeat (hold) @(negedge clk_in);
        run     = n_run;
        dir     = n_dir;
        msg_len = n_len;
        rstn    = 1'b1;
        apply_and_push();
    endtask

    // Monitor: compare the predicted outputs after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_in);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("offset", int'(offset), e.off);
                chk("tick", int'(tick), int'(e.tk));
                chk("wrap", int'(wrap), int'(e.wr));
                chk("blink", int'(blink), int'(e.bl));
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic cur_slow;
        logic cur_step;
        rstn     = 1'b1;
        slow_clk = 1'b1;
        step     = 1'b0;
        run      = 1'b1;
        dir      = 1'b0;
        msg_len  = 6'd4;
        n_run    = 1'b1;
        n_dir    = 1'b0;
        n_len    = 6'd4;
        model_reset();

        // Release with slow_clk high: no tick until it is seen low.
        do_reset(3, 1'b1);
        repeat (10) cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);

        // Forward scroll with wrap at length 4.
        do_reset(2, 1'b0);
        edges(5);

        // Reverse scroll with wrap at length 3.
        n_len = 6'd3;
        n_dir = 1'b1;
        do_reset(2, 1'b0);
        edges(4);

        // Paused: single steps only, slow edges still tick and blink.
        n_run = 1'b0;
        n_dir = 1'b0;
        n_len = 6'd8;
        do_reset(2, 1'b0);
        for (int i = 0; i < 40; i++) begin
            cyc(((i % 4) >= 2) ? 1'b1 : 1'b0,
                (i == 5 || (i >= 12 && i < 32) || i == 36) ? 1'b1 : 1'b0);
        end

        // Length shrink below the offset with a coincident edge, then length 0.
        n_run = 1'b1;
        n_len = 6'd8;
        do_reset(2, 1'b0);
        edges(5);
        n_len = 6'd3;
        cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        n_len = 6'd0;
        edges(3);

        // Reset mid-run right after a tick, release with slow_clk high.
        n_len = 6'd4;
        do_reset(2, 1'b0);
        edges(5);
        cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0);
        do_reset(3, 1'b1);
        repeat (5) cyc(1'b1, 1'b0);
        edges(2);

        // Randomized operation with occasional mode, length and reset changes.
        cur_slow = 1'b1;
        cur_step = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 40) == 0) n_run = ~n_run;
            if ($urandom_range(0, 30) == 0) n_dir = ~n_dir;
            if ($urandom_range(0, 60) == 0) n_len = LEN_W'($urandom_range(0, 12));
            if ($urandom_range(0, 2) == 0) cur_slow = ~cur_slow;
            if ($urandom_range(0, 3) == 0) cur_step = ~cur_step;
            if ($urandom_range(0, 499) == 0) begin
                do_reset(int'($urandom_range(1, 3)), cur_slow);
            end else begin
                cyc(cur_slow, cur_step);
            end
        end

        @(posedge clk_in);
        #3;
        chk("queue_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
